edac_err_log: RTL and testbench
===============================

EDAC_ERR_LOG -- requirements
Module: edac_err_log

Interface
REQ-001 Parameter RAM_LOGDEPTH, default 8, width of logged RAM address.
REQ-002 Parameter LOG_LOGDEPTH, default 2, log FIFO depth = 2**LOG_LOGDEPTH entries.
REQ-003 Parameter CNT_WIDTH, default 16, width of each event counter.
REQ-004 rClk  input  1  sole clock, all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 correctable  input  1  single-bit corrected on user read, one pulse per event.
REQ-007 error  input  1  uncorrectable error on user read.
REQ-008 scrub_corr  input  1  scrubber write-back of a corrected word.
REQ-009 evt_addr  input  RAM_LOGDEPTH  RAM address of the event, valid with the flags.
REQ-010 pop  input  1  consumer removes head entry.
REQ-011 clr_cnt  input  1  synchronous clear of counters and overflow flag.
REQ-012 irq_ack  input  1  clears irq.
REQ-013 entry_valid  output  1  log FIFO non-empty.
REQ-014 entry_type  output  2  head type: 01 correctable, 10 uncorrectable, 11 scrub correction.
REQ-015 entry_addr  output  RAM_LOGDEPTH  head address.
REQ-016 entry_ts  output  16  head timestamp (see Configuration).
REQ-017 corr_cnt, uncorr_cnt, scrub_cnt  output  CNT_WIDTH each  event counters.
REQ-018 overflow  output  1  sticky: event lost because log full.
REQ-019 irq  output  1  registered interrupt request.

Function
REQ-020 Each of correctable, error, scrub_corr asserted in a cycle SHALL increment its own counter by 1, all three independently in the same cycle.
REQ-021 Counters SHALL saturate at 2**CNT_WIDTH-1, no wrap.
REQ-022 clr_cnt SHALL zero all counters and overflow next edge; clr_cnt with a same-cycle event SHALL leave that counter at 1.
REQ-023 At most one entry SHALL be pushed per cycle, priority error > correctable > scrub_corr; lower-priority same-cycle events are counted only.
REQ-024 Log FIFO SHALL be show-ahead: event at edge N into empty log gives entry_valid=1 with that entry after edge N+1.
REQ-025 pop with entry_valid=1 SHALL advance head one edge later; pop while empty SHALL be ignored.
REQ-026 Push while full without same-cycle pop SHALL drop the entry and set overflow.
REQ-027 Push and pop same cycle while full SHALL accept both, occupancy unchanged, overflow unchanged.
REQ-028 Push and pop same cycle while empty SHALL accept the push, ignore the pop.
REQ-029 Read/write pointers SHALL be LOG_LOGDEPTH+1 bits, wrapping modulo 2**(LOG_LOGDEPTH+1); full = MSBs differ, rest equal.
REQ-030 irq SHALL set one edge after an uncorrectable entry is pushed or overflow rises; irq_ack clears it; set SHALL win over same-cycle irq_ack.
REQ-031 clr_cnt SHALL not modify FIFO contents or irq.

Reset
REQ-032 rst SHALL asynchronously clear pointers, counters, overflow, irq and timestamp; entry_valid=0, entry_type=00, entry_addr=0, entry_ts=0 while and after reset.
REQ-033 rst mid-operation SHALL discard all logged entries; events in the cycle rst releases SHALL be processed normally.

Configuration
REQ-034 Macro EDAC_ERR_LOG_TIMESTAMP_EN defined: 16-bit free-running counter, wrapping 0xFFFF->0, captured into each entry at push; entry_ts shows head timestamp.
REQ-035 Macro undefined: no timestamp counter or storage compiled; entry_ts tied to 0; all other behaviour identical.

Verification
REQ-036 rst, then correctable=1, evt_addr=0x12 one cycle -> next cycle entry_valid=1, entry_type=01, entry_addr=0x12, corr_cnt=1, irq=0.
REQ-037 error and scrub_corr same cycle, evt_addr=0x80 -> one entry type 10 addr 0x80, uncorr_cnt=1, scrub_cnt=1, irq=1 next cycle; irq_ack -> irq=0.
REQ-038 5 correctable events, no pop, depth 4 -> 4 entries retained, 5th dropped, overflow=1, irq=1, corr_cnt=5; 4 pops -> entry_valid=0.
REQ-039 Log full, push and pop same cycle -> occupancy stays 4, overflow stays 0, newest entry at tail.
REQ-040 Counter preset to 0xFFFE via 2**CNT_WIDTH-2 events, 3 more events -> corr_cnt=0xFFFF; clr_cnt -> 0.
REQ-041 With EDAC_ERR_LOG_TIMESTAMP_EN, events at timestamps 0xFFFF and 0x0001 -> entry_ts 0xFFFF then 0x0001; without macro entry_ts=0 throughout.

Source files
------------

// File: rtl/edac_err_log_if.sv
// Event/log/counter bundle for the EDAC error logger.
// master drives events and consumer controls; slave is the logger.
interface edac_err_log_if #(
  parameter int unsigned RAM_LOGDEPTH = 8,
  parameter int unsigned CNT_WIDTH    = 16
);
  logic                    correctable;
  logic                    error;
  logic                    scrub_corr;
  logic [RAM_LOGDEPTH-1:0] evt_addr;
  logic                    pop;
  logic                    clr_cnt;
  logic                    irq_ack;

  logic                    entry_valid;
  logic [1:0]              entry_type;
  logic [RAM_LOGDEPTH-1:0] entry_addr;
  logic [15:0]             entry_ts;
  logic [CNT_WIDTH-1:0]    corr_cnt;
  logic [CNT_WIDTH-1:0]    uncorr_cnt;
  logic [CNT_WIDTH-1:0]    scrub_cnt;
  logic                    overflow;
  logic                    irq;

  modport master (
    output correctable, error, scrub_corr, evt_addr, pop, clr_cnt, irq_ack,
    input  entry_valid, entry_type, entry_addr, entry_ts,
    input  corr_cnt, uncorr_cnt, scrub_cnt, overflow, irq
  );

  modport slave (
    input  correctable, error, scrub_corr, evt_addr, pop, clr_cnt, irq_ack,
    output entry_valid, entry_type, entry_addr, entry_ts,
    output corr_cnt, uncorr_cnt, scrub_cnt, overflow, irq
  );
endinterface

// File: rtl/edac_err_log.sv
// EDAC event logger: saturating event counters plus a show-ahead log FIFO with irq.
// Optional per-entry timestamps are compiled in with EDAC_ERR_LOG_TIMESTAMP_EN.
module edac_err_log #(
  parameter int unsigned RAM_LOGDEPTH = 8,
  parameter int unsigned LOG_LOGDEPTH = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic           rClk,
  input logic           rst,
  edac_err_log_if.slave bus
);
  localparam int unsigned Depth = 1 << LOG_LOGDEPTH;
  localparam int unsigned PtrW  = LOG_LOGDEPTH + 1;

  localparam logic [1:0] TypeCorr   = 2'b01;
  localparam logic [1:0] TypeUncorr = 2'b10;
  localparam logic [1:0] TypeScrub  = 2'b11;

  logic [PtrW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]    corr_q, corr_d, uncorr_q, uncorr_d, scrub_q, scrub_d;
  logic                    overflow_q, overflow_d;
  logic                    irq_q, irq_d;

  logic                    push, do_push, do_pop, drop, empty, full;
  logic [1:0]              push_type;
  logic [LOG_LOGDEPTH-1:0] widx, ridx;

  logic [1:0]              type_mem [Depth];
  logic [RAM_LOGDEPTH-1:0] addr_mem [Depth];

  // Clear wins over the old value, but a same-cycle event still counts once.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic evt, input logic clr);
    logic [CNT_WIDTH-1:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = evt ? CNT_WIDTH'(1) : '0;
    end else if (evt && (cur != {CNT_WIDTH{1'b1}})) begin
      nxt = cur + CNT_WIDTH'(1);
    end
    return nxt;
  endfunction

  assign widx  = wptr_q[LOG_LOGDEPTH-1:0];
  assign ridx  = rptr_q[LOG_LOGDEPTH-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                 (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);

  always_comb begin
    push      = bus.error | bus.correctable | bus.scrub_corr;
    push_type = TypeScrub;
    if (bus.error) begin
      push_type = TypeUncorr;
    end else if (bus.correctable) begin
      push_type = TypeCorr;
    end

    do_pop  = bus.pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;

    wptr_d = do_push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = do_pop  ? rptr_q + PtrW'(1) : rptr_q;

    corr_d   = cnt_next(corr_q,   bus.correctable, bus.clr_cnt);
    uncorr_d = cnt_next(uncorr_q, bus.error,       bus.clr_cnt);
    scrub_d  = cnt_next(scrub_q,  bus.scrub_corr,  bus.clr_cnt);

    overflow_d = (overflow_q && !bus.clr_cnt) || drop;

    // Setting takes precedence over a same-cycle acknowledge.
    irq_d = irq_q && !bus.irq_ack;
    if ((do_push && push_type == TypeUncorr) || (overflow_d && !overflow_q)) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge rClk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      corr_q     <= '0;
      uncorr_q   <= '0;
      scrub_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      corr_q     <= corr_d;
      uncorr_q   <= uncorr_d;
      scrub_q    <= scrub_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the log is empty.
  always_ff @(posedge rClk) begin
    if (do_push) begin
      type_mem[widx] <= push_type;
      addr_mem[widx] <= bus.evt_addr;
    end
  end

`ifdef EDAC_ERR_LOG_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_mem [Depth];

  always_ff @(posedge rClk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 16'd1;
    end
  end

  always_ff @(posedge rClk) begin
    if (do_push) begin
      ts_mem[widx] <= ts_q;
    end
  end

  assign bus.entry_ts = empty ? 16'h0000 : ts_mem[ridx];
`else
  assign bus.entry_ts = 16'h0000;
`endif

  assign bus.entry_valid = !empty;
  assign bus.entry_type  = empty ? 2'b00 : type_mem[ridx];
  assign bus.entry_addr  = empty ? '0 : addr_mem[ridx];
  assign bus.corr_cnt    = corr_q;
  assign bus.uncorr_cnt  = uncorr_q;
  assign bus.scrub_cnt   = scrub_q;
  assign bus.overflow    = overflow_q;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_edac_err_log.sv
// Directed bench for edac_err_log: a per-cycle vector table plus hand-written
// sequences for reset, counter saturation and (when enabled) timestamp wrap.
module tb_edac_err_log;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned MAXC  = (1 << CNT_W) - 1;

  logic rClk;
  logic rst;
  int   n_vec;
  int   n_err;

  edac_err_log_if #(.RAM_LOGDEPTH(8), .CNT_WIDTH(CNT_W)) bus ();

  edac_err_log #(
    .RAM_LOGDEPTH(8),
    .LOG_LOGDEPTH(2),
    .CNT_WIDTH   (CNT_W)
  ) dut (
    .rClk(rClk),
    .rst (rst),
    .bus (bus)
  );

  initial rClk = 1'b0;
  always #5 rClk = ~rClk;

  typedef struct {
    logic       c, e, s;
    logic [7:0] a;
    logic       p, cl, ak;
    logic       v;
    logic [1:0] t;
    logic [7:0] ea;
    int         cc, uc, sc;
    logic       ov, irq;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic c, e, s, input logic [7:0] a,
                              input logic p, cl, ak, input logic v,
                              input logic [1:0] t, input logic [7:0] ea,
                              input int cc, uc, sc, input logic ov, irq);
    vec_t r;
    r.c = c; r.e = e; r.s = s; r.a = a; r.p = p; r.cl = cl; r.ak = ak;
    r.v = v; r.t = t; r.ea = ea; r.cc = cc; r.uc = uc; r.sc = sc;
    r.ov = ov; r.irq = irq;
    return r;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic c, e, s, input logic [7:0] a,
                       input logic p, cl, ak);
    bus.correctable = c;
    bus.error       = e;
    bus.scrub_corr  = s;
    bus.evt_addr    = a;
    bus.pop         = p;
    bus.clr_cnt     = cl;
    bus.irq_ack     = ak;
  endtask

  // Drive for one cycle, then land 1 time unit after the edge for sampling.
  task automatic step(input logic c, e, s, input logic [7:0] a,
                      input logic p, cl, ak);
    drive(c, e, s, a, p, cl, ak);
    @(posedge rClk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    //          c  e  s  addr   p  cl ak   v  type   eaddr  cc uc sc ov irq
    vecs[0]  = mk(1, 0, 0, 8'h12, 0, 0, 0, 1, 2'b01, 8'h12, 1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00, 8'h00, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 8'h80, 0, 0, 0, 1, 2'b10, 8'h80, 1, 1, 1, 0, 1);
    vecs[3]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 1, 2'b10, 8'h80, 1, 1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00, 8'h00, 1, 1, 1, 0, 0);
    vecs[5]  = mk(1, 0, 0, 8'h05, 1, 0, 0, 1, 2'b01, 8'h05, 2, 1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 1, 8'h33, 0, 0, 0, 1, 2'b01, 8'h05, 2, 1, 2, 0, 0);
    vecs[7]  = mk(1, 0, 0, 8'h21, 0, 0, 0, 1, 2'b01, 8'h05, 3, 1, 2, 0, 0);
    vecs[8]  = mk(1, 0, 0, 8'h22, 0, 0, 0, 1, 2'b01, 8'h05, 4, 1, 2, 0, 0);
    vecs[9]  = mk(1, 0, 0, 8'h23, 0, 0, 0, 1, 2'b01, 8'h05, 5, 1, 2, 1, 1);
    vecs[10] = mk(0, 0, 0, 8'h00, 0, 1, 1, 1, 2'b01, 8'h05, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 8'h44, 1, 0, 0, 1, 2'b11, 8'h33, 0, 1, 0, 0, 1);
    vecs[12] = mk(0, 0, 0, 8'h00, 1, 0, 1, 1, 2'b01, 8'h21, 0, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 2'b01, 8'h22, 0, 1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 2'b10, 8'h44, 0, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00, 8'h00, 0, 1, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 8'h01, 0, 1, 0, 1, 2'b01, 8'h01, 1, 0, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 8'h02, 0, 0, 1, 1, 2'b01, 8'h01, 1, 1, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 2'b10, 8'h02, 1, 1, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 8'h00, 1, 0, 1, 0, 2'b00, 8'h00, 1, 1, 0, 0, 0);

    repeat (2) @(posedge rClk);
    #1;
    chk("rst_valid", 0, 32'(bus.entry_valid), 32'd0);
    chk("rst_type",  0, 32'(bus.entry_type),  32'd0);
    chk("rst_addr",  0, 32'(bus.entry_addr),  32'd0);
    chk("rst_ts",    0, 32'(bus.entry_ts),    32'd0);
    chk("rst_cnt",   0, 32'(bus.corr_cnt | bus.uncorr_cnt | bus.scrub_cnt), 32'd0);
    chk("rst_ovf",   0, 32'(bus.overflow),    32'd0);
    chk("rst_irq",   0, 32'(bus.irq),         32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].c, vecs[i].e, vecs[i].s, vecs[i].a, vecs[i].p, vecs[i].cl, vecs[i].ak);
      chk("valid",    i, 32'(bus.entry_valid), 32'(vecs[i].v));
      chk("type",     i, 32'(bus.entry_type),  32'(vecs[i].t));
      chk("addr",     i, 32'(bus.entry_addr),  32'(vecs[i].ea));
      chk("corr_cnt", i, 32'(bus.corr_cnt),    32'(vecs[i].cc));
      chk("uncorr",   i, 32'(bus.uncorr_cnt),  32'(vecs[i].uc));
      chk("scrub",    i, 32'(bus.scrub_cnt),   32'(vecs[i].sc));
      chk("overflow", i, 32'(bus.overflow),    32'(vecs[i].ov));
      chk("irq",      i, 32'(bus.irq),         32'(vecs[i].irq));
`ifndef EDAC_ERR_LOG_TIMESTAMP_EN
      chk("ts_zero",  i, 32'(bus.entry_ts),    32'd0);
`endif
    end

    // Mid-operation reset discards the log; an event in the release cycle is kept.
    step(1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 0, 32'(bus.entry_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("arst_valid", 0, 32'(bus.entry_valid), 32'd0);
    chk("arst_addr",  0, 32'(bus.entry_addr),  32'd0);
    chk("arst_corr",  0, 32'(bus.corr_cnt),    32'd0);
    chk("arst_scrub", 0, 32'(bus.scrub_cnt),   32'd0);
    @(posedge rClk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("rel_valid", 0, 32'(bus.entry_valid), 32'd1);
    chk("rel_type",  0, 32'(bus.entry_type),  32'd1);
    chk("rel_addr",  0, 32'(bus.entry_addr),  32'h55);
    chk("rel_corr",  0, 32'(bus.corr_cnt),    32'd1);

    // Counter saturation.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("sat_clr0", 0, 32'(bus.corr_cnt), 32'd0);
    repeat (MAXC - 1) step(1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
    chk("sat_preset", 0, 32'(bus.corr_cnt), 32'(MAXC - 1));
    chk("sat_ovf",    0, 32'(bus.overflow), 32'd1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
    chk("sat_max", 0, 32'(bus.corr_cnt), 32'(MAXC));
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("sat_clr",     0, 32'(bus.corr_cnt), 32'd0);
    chk("sat_clr_ovf", 0, 32'(bus.overflow), 32'd0);
    chk("sat_fifo",    0, 32'(bus.entry_valid), 32'd1);

`ifdef EDAC_ERR_LOG_TIMESTAMP_EN
    // Timestamp wrap: reset zeroes the counter, then count edges to 0xFFFF.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge rClk);
    #1;
    rst = 1'b0;
    repeat (65535) idle();
    step(1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b1, 1'b0, 1'b0, 8'hA2, 1'b0, 1'b0, 1'b0);
    chk("ts_first",  0, 32'(bus.entry_ts),   32'h0000FFFF);
    chk("ts_addr1",  0, 32'(bus.entry_addr), 32'hA1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("ts_second", 0, 32'(bus.entry_ts),   32'h00000001);
    chk("ts_addr2",  0, 32'(bus.entry_addr), 32'hA2);
`else
    chk("ts_off", 0, 32'(bus.entry_ts), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
